// File: rtl/pcie_tsos_rx.sv
// PCIe TS1/TS2 ordered-set receiver: frames COM-aligned 16-symbol training sets, exports the
// fields of each well-formed set and counts consecutive identical sets.
module pcie_tsos_rx #(
    parameter int unsigned CONSEC_TARGET = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sym_data_i,
    input  logic       sym_k_i,
    input  logic       sym_valid_i,
    input  logic       clear_cnt_i,
    output logic       tsos_valid_o,
    output logic       tsos_type_o,
    output logic [7:0] link_num_o,
    output logic [7:0] lane_num_o,
    output logic [7:0] n_fts_o,
    output logic [7:0] rate_id_o,
    output logic [7:0] train_ctl_o,
    output logic       link_pad_o,
    output logic       lane_pad_o,
    output logic [3:0] consec_cnt_o,
    output logic       consec_met_o,
    output logic       err_o
);

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;
    localparam logic [3:0] TARGET = 4'(CONSEC_TARGET);

    typedef enum logic {StHunt, StCollect} state_t;

    state_t     state;
    logic [3:0] idx;
    logic [7:0] link_sh, lane_sh, nfts_sh, rate_sh, ctl_sh;
    logic       link_pad_sh, lane_pad_sh, type_sh;
    logic       ref_valid;

    logic       is_com, sym_ok, accept, abort, match, ref_next;
    logic [3:0] cnt_next;

    always_comb begin
        is_com = sym_k_i && (sym_data_i == COM);
        case (idx)
            4'd1, 4'd2:       sym_ok = !sym_k_i || (sym_data_i == PAD);
            4'd3, 4'd4, 4'd5: sym_ok = !sym_k_i;
            4'd6:             sym_ok = !sym_k_i && ((sym_data_i == TS1_ID) ||
                                                    (sym_data_i == TS2_ID));
            default:          sym_ok = !sym_k_i && (sym_data_i == (type_sh ? TS2_ID : TS1_ID));
        endcase
        accept = sym_valid_i && (state == StCollect) && sym_ok && (idx == 4'd15);
        abort  = sym_valid_i && (state == StCollect) && !sym_ok;

        // The registered field outputs double as the prior-set reference.
        match = ref_valid && (type_sh == tsos_type_o) &&
                ({link_sh, lane_sh, nfts_sh, rate_sh, ctl_sh, link_pad_sh, lane_pad_sh} ==
                 {link_num_o, lane_num_o, n_fts_o, rate_id_o, train_ctl_o, link_pad_o,
                  lane_pad_o});

        cnt_next = consec_cnt_o;
        if (accept) begin
            if (!match)                     cnt_next = 4'd1;
            else if (consec_cnt_o != 4'd15) cnt_next = consec_cnt_o + 4'd1;
        end
        if (abort || clear_cnt_i) cnt_next = 4'd0;

        ref_next = accept ? 1'b1 : (clear_cnt_i ? 1'b0 : ref_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StHunt;
            idx          <= 4'd0;
            link_sh      <= 8'h00;
            lane_sh      <= 8'h00;
            nfts_sh      <= 8'h00;
            rate_sh      <= 8'h00;
            ctl_sh       <= 8'h00;
            link_pad_sh  <= 1'b0;
            lane_pad_sh  <= 1'b0;
            type_sh      <= 1'b0;
            ref_valid    <= 1'b0;
            tsos_valid_o <= 1'b0;
            tsos_type_o  <= 1'b0;
            link_num_o   <= 8'h00;
            lane_num_o   <= 8'h00;
            n_fts_o      <= 8'h00;
            rate_id_o    <= 8'h00;
            train_ctl_o  <= 8'h00;
            link_pad_o   <= 1'b0;
            lane_pad_o   <= 1'b0;
            consec_cnt_o <= 4'd0;
            consec_met_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            tsos_valid_o <= accept;
            err_o        <= abort;
            consec_cnt_o <= cnt_next;
            consec_met_o <= (cnt_next >= TARGET);
            ref_valid    <= ref_next;
            if (accept) begin
                tsos_type_o <= type_sh;
                link_num_o  <= link_sh;
                lane_num_o  <= lane_sh;
                n_fts_o     <= nfts_sh;
                rate_id_o   <= rate_sh;
                train_ctl_o <= ctl_sh;
                link_pad_o  <= link_pad_sh;
                lane_pad_o  <= lane_pad_sh;
            end
            if (sym_valid_i) begin
                case (state)
                    StHunt: begin
                        if (is_com) begin
                            state <= StCollect;
                            idx   <= 4'd1;
                        end
                    end
                    StCollect: begin
                        if (!sym_ok) begin
                            // A COM that breaks a set is the start of the next one.
                            if (is_com) begin
                                idx <= 4'd1;
                            end else begin
                                state <= StHunt;
                                idx   <= 4'd0;
                            end
                        end else if (idx == 4'd15) begin
                            state <= StHunt;
                            idx   <= 4'd0;
                        end else begin
                            idx <= idx + 4'd1;
                            case (idx)
                                4'd1: begin
                                    link_sh     <= sym_data_i;
                                    link_pad_sh <= sym_k_i;
                                end
                                4'd2: begin
                                    lane_sh     <= sym_data_i;
                                    lane_pad_sh <= sym_k_i;
                                end
                                4'd3:    nfts_sh <= sym_data_i;
                                4'd4:    rate_sh <= sym_data_i;
                                4'd5:    ctl_sh  <= sym_data_i;
                                4'd6:    type_sh <= (sym_data_i == TS2_ID);
                                default: ;
                            endcase
                        end
                    end
                    default: state <= StHunt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcie_tsos_rx.sv
// Directed, table-driven bench for pcie_tsos_rx: whole training sets are applied from a vector
// table, with hand-written sequences for resync and reset corner cases.
module tb_pcie_tsos_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sym_data_i = 8'h00;
    logic       sym_k_i = 1'b0;
    logic       sym_valid_i = 1'b0;
    logic       clear_cnt_i = 1'b0;
    logic       tsos_valid_o, tsos_type_o, link_pad_o, lane_pad_o, consec_met_o, err_o;
    logic [7:0] link_num_o, lane_num_o, n_fts_o, rate_id_o, train_ctl_o;
    logic [3:0] consec_cnt_o;

    pcie_tsos_rx #(.CONSEC_TARGET(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sym_data_i   (sym_data_i),
        .sym_k_i      (sym_k_i),
        .sym_valid_i  (sym_valid_i),
        .clear_cnt_i  (clear_cnt_i),
        .tsos_valid_o (tsos_valid_o),
        .tsos_type_o  (tsos_type_o),
        .link_num_o   (link_num_o),
        .lane_num_o   (lane_num_o),
        .n_fts_o      (n_fts_o),
        .rate_id_o    (rate_id_o),
        .train_ctl_o  (train_ctl_o),
        .link_pad_o   (link_pad_o),
        .lane_pad_o   (lane_pad_o),
        .consec_cnt_o (consec_cnt_o),
        .consec_met_o (consec_met_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ts2;
        logic [7:0] link, lane, nfts, rate, ctl;
        logic       lpad, npad;
        int         bad_idx;
        logic       bad_k;
        logic [7:0] bad_data;
        logic       clr;
        logic       gap;
        logic       exp_valid;
        logic       exp_err;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t        tv[$];
    int          checks = 0;
    int          errors = 0;
    int          n_valid = 0;
    int          n_err = 0;
    int          exp_total = 0;
    int          e0, v0;
    logic [41:0] m_f = '0;
    logic        m_type = 1'b0;

    // Counted at the rising edge, before the DUT updates: each pulse is seen exactly once.
    always @(posedge clk) begin
        if (tsos_valid_o) n_valid++;
        if (err_o) n_err++;
    end

    function automatic logic [41:0] dut_fields();
        return {link_num_o, lane_num_o, n_fts_o, rate_id_o, train_ctl_o, link_pad_o, lane_pad_o};
    endfunction

    function automatic vec_t mk(input logic ts2, input int fs, input int bad_idx,
                                input logic bad_k, input logic [7:0] bad_data, input logic clr,
                                input logic gap, input logic ev, input logic ee,
                                input logic [3:0] ec);
        vec_t v;
        v.ts2 = ts2;
        if (fs == 0) begin
            v.link = 8'hF7; v.lpad = 1'b1; v.lane = 8'hF7; v.npad = 1'b1;
            v.nfts = 8'h10; v.rate = 8'h0E; v.ctl = 8'h00;
        end else begin
            v.link = 8'h01; v.lpad = 1'b0; v.lane = 8'h00; v.npad = 1'b0;
            v.nfts = 8'h20; v.rate = 8'h02; v.ctl = 8'h01;
            if (fs == 2) begin
                v.lane = 8'hF7; v.npad = 1'b1;
            end
        end
        v.bad_idx = bad_idx; v.bad_k = bad_k; v.bad_data = bad_data;
        v.clr = clr; v.gap = gap; v.exp_valid = ev; v.exp_err = ee; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Holds the symbol for one clock; returns at the next falling edge.
    task automatic send_sym(input logic k, input logic [7:0] d, input logic clr, input logic gap);
        if (gap) begin
            sym_valid_i = 1'b0; sym_k_i = 1'b1; sym_data_i = 8'hBC; clear_cnt_i = 1'b0;
            @(negedge clk);
        end
        sym_valid_i = 1'b1; sym_k_i = k; sym_data_i = d; clear_cnt_i = clr;
        @(negedge clk);
    endtask

    task automatic idle();
        sym_valid_i = 1'b0; sym_k_i = 1'b0; sym_data_i = 8'h00; clear_cnt_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_set(input vec_t v);
        logic [7:0] sd[16];
        logic       sk[16];
        sd[0] = 8'hBC;  sk[0] = 1'b1;
        sd[1] = v.link; sk[1] = v.lpad;
        sd[2] = v.lane; sk[2] = v.npad;
        sd[3] = v.nfts; sd[4] = v.rate; sd[5] = v.ctl;
        for (int i = 3; i < 16; i++) sk[i] = 1'b0;
        for (int i = 6; i < 16; i++) sd[i] = v.ts2 ? 8'h45 : 8'h4A;
        if (v.bad_idx > 0) begin
            sd[v.bad_idx] = v.bad_data;
            sk[v.bad_idx] = v.bad_k;
        end
        for (int i = 0; i < 16; i++) send_sym(sk[i], sd[i], (i == 15) && v.clr, v.gap);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t rs;
        repeat (2) @(negedge clk);
        chk("rst_valid", 0, tsos_valid_o, 1'b0);
        chk("rst_err", 0, err_o, 1'b0);
        chk("rst_cnt", 0, consec_cnt_o, 4'd0);
        chk("rst_met", 0, consec_met_o, 1'b0);
        chk("rst_type", 0, tsos_type_o, 1'b0);
        chk("rst_fields", 0, dut_fields(), 42'd0);
        rst_n = 1'b1;

        // Non-COM symbols while hunting are silently dropped.
        send_sym(1'b1, 8'hF7, 1'b0, 1'b0);
        send_sym(1'b0, 8'h4A, 1'b0, 1'b0);
        send_sym(1'b1, 8'h1C, 1'b0, 1'b0);
        idle(); idle();
        chk("hunt_err", 0, 64'(n_err), 64'd0);
        chk("hunt_valid", 0, 64'(n_valid), 64'd0);

        // fs: 0 = TS-A (PAD/PAD/10/0E/00), 1 = TS-B (01/00/20/02/01), 2 = TS-B with lane PAD
        for (int i = 0; i < 16; i++)
            tv.push_back(mk(1'b0, 0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,
                            (i < 15) ? 4'(i + 1) : 4'd15));
        tv.push_back(mk(1'b1, 0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1));
        tv.push_back(mk(1'b1, 0, 9, 1'b0, 8'h4A, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
        tv.push_back(mk(1'b0, 0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1));
        tv.push_back(mk(1'b0, 0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2));
        tv.push_back(mk(1'b0, 0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3));
        tv.push_back(mk(1'b0, 0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4));
        tv.push_back(mk(1'b0, 0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
        tv.push_back(mk(1'b0, 0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1));
        tv.push_back(mk(1'b0, 0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2));
        tv.push_back(mk(1'b0, 1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1));
        tv.push_back(mk(1'b0, 1, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2));
        tv.push_back(mk(1'b0, 1, 2, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
        tv.push_back(mk(1'b0, 1, 6, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
        tv.push_back(mk(1'b0, 1, 4, 1'b1, 8'hF7, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
        tv.push_back(mk(1'b1, 1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1));
        tv.push_back(mk(1'b1, 2, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1));
        tv.push_back(mk(1'b1, 2, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2));

        foreach (tv[i]) begin
            e0 = n_err;
            send_set(tv[i]);
            if (tv[i].exp_valid) begin
                m_f = {tv[i].link, tv[i].lane, tv[i].nfts, tv[i].rate, tv[i].ctl,
                       tv[i].lpad, tv[i].npad};
                m_type = tv[i].ts2;
                exp_total++;
            end
            chk("valid", i, tsos_valid_o, tv[i].exp_valid);
            chk("err_pulses", i, 64'(n_err - e0), 64'(tv[i].exp_err));
            chk("cnt", i, consec_cnt_o, tv[i].exp_cnt);
            chk("met", i, consec_met_o, tv[i].exp_cnt >= 4'd8);
            chk("type", i, tsos_type_o, m_type);
            chk("fields", i, dut_fields(), m_f);
        end

        // COM at index 8 resyncs straight into a full TS2.
        e0 = n_err;
        send_sym(1'b1, 8'hBC, 1'b0, 1'b0);
        send_sym(1'b1, 8'hF7, 1'b0, 1'b0);
        send_sym(1'b1, 8'hF7, 1'b0, 1'b0);
        send_sym(1'b0, 8'h10, 1'b0, 1'b0);
        send_sym(1'b0, 8'h0E, 1'b0, 1'b0);
        send_sym(1'b0, 8'h00, 1'b0, 1'b0);
        send_sym(1'b0, 8'h4A, 1'b0, 1'b0);
        send_sym(1'b0, 8'h4A, 1'b0, 1'b0);
        rs = mk(1'b1, 0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
        send_set(rs);
        exp_total++;
        m_f = {8'hF7, 8'hF7, 8'h10, 8'h0E, 8'h00, 1'b1, 1'b1};
        chk("resync_err", 0, 64'(n_err - e0), 64'd1);
        chk("resync_valid", 0, tsos_valid_o, 1'b1);
        chk("resync_type", 0, tsos_type_o, 1'b1);
        chk("resync_cnt", 0, consec_cnt_o, 4'd1);
        chk("resync_fields", 0, dut_fields(), m_f);
        idle(); idle();
        chk("valid_total", 0, 64'(n_valid), 64'(exp_total));

        // Reset in the middle of a set: outputs clear at once, remainder is ignored.
        e0 = n_err;
        v0 = n_valid;
        send_sym(1'b1, 8'hBC, 1'b0, 1'b0);
        send_sym(1'b0, 8'h01, 1'b0, 1'b0);
        send_sym(1'b0, 8'h00, 1'b0, 1'b0);
        send_sym(1'b0, 8'h20, 1'b0, 1'b0);
        send_sym(1'b0, 8'h02, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        m_f = '0;
        m_type = 1'b0;
        chk("mid_rst_cnt", 0, consec_cnt_o, 4'd0);
        chk("mid_rst_type", 0, tsos_type_o, 1'b0);
        chk("mid_rst_fields", 0, dut_fields(), m_f);
        @(negedge clk);
        rst_n = 1'b1;
        send_sym(1'b0, 8'h01, 1'b0, 1'b0);
        for (int i = 6; i < 16; i++) send_sym(1'b0, 8'h4A, 1'b0, 1'b0);
        idle(); idle();
        chk("mid_rst_err", 0, 64'(n_err - e0), 64'd0);
        chk("mid_rst_valid", 0, 64'(n_valid - v0), 64'd0);
        chk("mid_rst_cnt_after", 0, consec_cnt_o, 4'd0);

        // COM presented on the first edge after reset release is honoured.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rs = mk(1'b0, 0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
        send_set(rs);
        exp_total++;
        m_f = {8'hF7, 8'hF7, 8'h10, 8'h0E, 8'h00, 1'b1, 1'b1};
        chk("post_rst_valid", 0, tsos_valid_o, 1'b1);
        chk("post_rst_cnt", 0, consec_cnt_o, 4'd1);
        chk("post_rst_type", 0, tsos_type_o, 1'b0);
        chk("post_rst_fields", 0, dut_fields(), m_f);
        idle(); idle();
        chk("valid_total_end", 0, 64'(n_valid), 64'(exp_total));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
